// File: rtl/alu_pipe_ctrl.sv
// Two-stage (decode / execute) ALU pipeline with valid/ready handshakes and a result counter.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_pipe_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count,
    output logic             ovf_sticky,
    input  logic             ovf_clear
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } op_e;

    logic             d_valid_q, d_valid_d;
    logic [WIDTH-1:0] d_a_q, d_b_q;
    op_e              d_op_q, dec_op;
    logic             d_slt_q, dec_slt;

    logic             e_valid_q, e_valid_d;
    logic [WIDTH-1:0] e_result_q;
    logic             e_carry_q, e_ovf_q, e_zero_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             e_adv, out_xfer;
    logic [WIDTH-1:0] b_opnd, x_res;
    logic [WIDTH:0]   sum;
    logic             add_ovf, x_carry, x_ovf;

    always_comb begin
        e_adv     = !e_valid_q || out_ready;
        in_ready  = !d_valid_q || e_adv;
        out_xfer  = e_valid_q && out_ready;
        d_valid_d = in_ready ? in_valid : d_valid_q;
        e_valid_d = e_adv ? d_valid_q : e_valid_q;
        cnt_d     = out_xfer ? cnt_q + 1'b1 : cnt_q;
        dec_slt   = (in_cmd == OP_SLT);
        dec_op    = dec_slt ? OP_SUB : op_e'(in_cmd);
    end

    // SLT reuses the SUB datapath; its result is derived from the difference sign and overflow.
    always_comb begin
        b_opnd  = (d_op_q == OP_SUB) ? ~d_b_q : d_b_q;
        sum     = {1'b0, d_a_q} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, (d_op_q == OP_SUB)};
        add_ovf = (d_a_q[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != d_a_q[WIDTH-1]);
        x_res   = '0;
        x_carry = 1'b0;
        x_ovf   = 1'b0;
        case (d_op_q)
            OP_ADD, OP_SUB: begin
                x_res   = sum[WIDTH-1:0];
                x_carry = sum[WIDTH];
                x_ovf   = add_ovf;
            end
            OP_XOR:  x_res = d_a_q ^ d_b_q;
            OP_AND:  x_res = d_a_q & d_b_q;
            OP_NAND: x_res = ~(d_a_q & d_b_q);
            OP_NOR:  x_res = ~(d_a_q | d_b_q);
            OP_OR:   x_res = d_a_q | d_b_q;
            default: x_res = '0;
        endcase
        if (d_slt_q) begin
            x_res   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            x_carry = 1'b0;
            x_ovf   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid_q  <= 1'b0;
            d_a_q      <= '0;
            d_b_q      <= '0;
            d_op_q     <= OP_ADD;
            d_slt_q    <= 1'b0;
            e_valid_q  <= 1'b0;
            e_result_q <= '0;
            e_carry_q  <= 1'b0;
            e_ovf_q    <= 1'b0;
            e_zero_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            e_valid_q <= e_valid_d;
            cnt_q     <= cnt_d;
            if (in_ready && in_valid) begin
                d_a_q   <= in_a;
                d_b_q   <= in_b;
                d_op_q  <= dec_op;
                d_slt_q <= dec_slt;
            end
            if (e_adv && d_valid_q) begin
                e_result_q <= x_res;
                e_carry_q  <= x_carry;
                e_ovf_q    <= x_ovf;
                e_zero_q   <= (x_res == '0);
            end
        end
    end

    assign out_valid  = e_valid_q;
    assign out_result = e_result_q;
    assign out_carry  = e_carry_q;
    assign out_ovf    = e_ovf_q;
    assign out_zero   = e_zero_q;
    assign op_count   = cnt_q;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // A new overflow takes priority over a clear arriving in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (out_xfer && e_ovf_q)
            sticky_d = 1'b1;
        else if (ovf_clear)
            sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            sticky_q <= 1'b0;
        else
            sticky_q <= sticky_d;
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_ovf_clear;
    assign unused_ovf_clear = ovf_clear;
    assign ovf_sticky       = 1'b0;
`endif

endmodule

// File: doc/alu_pipe_ctrl.md
ALU_PIPE_CTRL -- requirements
Module: alu_pipe_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on in_a/in_b/in_cmd.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 in_cmd  input  3  ALU command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
REQ-009 out_valid  output  1  result present on out_* ports.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 out_result  output  WIDTH  operation result.
REQ-012 out_carry, out_ovf, out_zero  output  1 each  carry-out, signed overflow, result-equals-zero.
REQ-013 op_count  output  CNT_W  number of results accepted by consumer since reset.
REQ-014 ovf_sticky  output  1  sticky overflow indicator (see Configuration).
REQ-015 ovf_clear  input  1  clears ovf_sticky.

Function
REQ-016 Transfer occurs on input when in_valid and in_ready are both 1 at a rising edge; on output when out_valid and out_ready are both 1.
REQ-017 Two-stage pipeline: stage D registers operands plus decoded mux index and isSlt flag; stage E registers result and flags.
REQ-018 Decode: SLT maps to mux index SUB with isSlt=1; every other command maps to itself with isSlt=0.
REQ-019 Latency: an accepted request appears on out_valid exactly 2 cycles later when out_ready has been held 1.
REQ-020 Throughput: one request per cycle sustained while out_ready=1.
REQ-021 in_ready = !D_valid OR (E advancing); E advances when !E_valid OR out_ready; no combinational path from in_valid to in_ready.
REQ-022 Stall: while out_valid=1 and out_ready=0, out_* and stage D contents hold unchanged; no request is lost or duplicated.
REQ-023 ADD/SUB: WIDTH-bit two's-complement; SUB computes a + ~b + 1; out_carry is carry out of MSB; out_ovf set when operand signs (b inverted for SUB) agree and result sign differs.
REQ-024 SLT: out_result = {WIDTH-1 zeros, (a-b sign) XOR (a-b overflow)}; out_carry and out_ovf forced 0.
REQ-025 Logic ops (XOR/AND/NAND/NOR/OR): bitwise on WIDTH bits; out_carry and out_ovf forced 0.
REQ-026 out_zero = 1 exactly when out_result is all zeros, for every command.
REQ-027 op_count increments by 1 on each output transfer; wraps from 2^CNT_W-1 to 0 without flag.
REQ-028 out_* data ports are don't-care while out_valid=0 but SHALL not be X after reset.

Reset
REQ-029 On reset: D_valid=0, E_valid=0, out_valid=0, out_result=0, out_carry=0, out_ovf=0, out_zero=0, op_count=0, ovf_sticky=0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-operation discards all in-flight requests; no output transfer counted in the reset cycle.

Configuration
REQ-032 Macro ALU_STICKY_OVF_EN: when defined, ovf_sticky sets on any output transfer with out_ovf=1 and holds until ovf_clear=1 or reset.
REQ-033 Simultaneous set and ovf_clear in one cycle: set wins (ovf_sticky=1).
REQ-034 Without ALU_STICKY_OVF_EN: ovf_sticky tied to 0, ovf_clear ignored, no sticky register synthesised.

Verification
REQ-035 WIDTH=32, out_ready=1: ADD a=0x7FFFFFFF b=1 -> 2 cycles later result 0x80000000, ovf=1, carry=0, zero=0.
REQ-036 SUB a=5 b=5 -> result 0, zero=1, carry=1, ovf=0; SLT a=0xFFFFFFFF b=1 -> result 1; SLT a=1 b=0xFFFFFFFF -> result 0.
REQ-037 Back-to-back 8 requests (all 8 commands), out_ready=1 -> 8 results in order on consecutive cycles, op_count=8.
REQ-038 out_ready=0 for 5 cycles after 3 requests offered -> in_ready drops after 2 accepted, outputs held, release delivers 3 results in order, none lost.
REQ-039 CNT_W=4, 17 output transfers -> op_count=1; reset asserted with 2 requests in flight -> out_valid=0 next cycle, op_count=0.
REQ-040 With ALU_STICKY_OVF_EN: overflowing ADD then ovf_clear=1 in the same cycle as a second overflowing transfer -> ovf_sticky stays 1; without macro -> ovf_sticky 0 throughout.
